quad_encoder_speed: RTL and testbench
=====================================

QUAD_ENCODER_SPEED -- requirements
Module: quad_encoder_speed

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, width of period, position and counters.
REQ-002 The block SHALL have parameter FILTER_LEN, default 4, the number of consecutive equal samples needed to accept a pin level (range 1..15).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 encoder_a  input  1  asynchronous quadrature channel A.
REQ-006 encoder_b  input  1  asynchronous quadrature channel B.
REQ-007 clear_pos  input  1  synchronous position clear, active high.
REQ-008 period_out  output  DATA_WIDTH  clk cycles between consecutive accepted A rising edges; all-ones means stalled.
REQ-009 period_valid  output  1  one-cycle pulse when period_out is updated.
REQ-010 direction  output  2  2'b10 forward, 2'b01 reverse, 2'b00 stopped.
REQ-011 position  output  DATA_WIDTH  signed two's-complement quadrature step count.
REQ-012 stalled  output  1  high while no A rising edge has occurred within 2^DATA_WIDTH-1 cycles.
REQ-013 quad_error  output  1  one-cycle pulse on an illegal double-bit transition.

Function
REQ-014 Each encoder pin SHALL pass through a two-flop synchronizer and then a glitch filter.
REQ-015 The filter output SHALL take a new level only after FILTER_LEN consecutive synchronized samples equal that level, so a pin change held stable appears filtered exactly FILTER_LEN+2 cycles later.
REQ-016 Pulses shorter than FILTER_LEN cycles SHALL never change the filtered level.
REQ-017 Decoding on the filtered {A,B} SHALL be as follows: 00->01->11->10->00 is forward, so position +1 and direction 2'b10; the reverse sequence is position -1 and direction 2'b01.
REQ-018 Both filtered bits changing in one cycle SHALL pulse quad_error for one cycle and leave position and direction unchanged.
REQ-019 position, direction and quad_error SHALL be registered one cycle after the filtered change, giving a total pin-to-output latency of FILTER_LEN+3 cycles.
REQ-020 position SHALL wrap modulo 2^DATA_WIDTH (0x7FFF+1 gives 0x8000 at 16 bits).
REQ-021 If clear_pos and a step occur in the same cycle, clear SHALL win and position SHALL be 0.
REQ-022 The period counter SHALL increment every cycle and saturate at all-ones.
REQ-023 On a filtered A rising edge the period counter SHALL restart at 1.
REQ-024 The state machine SHALL have three states: ARM (after reset), RUN and STALL.
REQ-025 ARM: the first A rising edge SHALL go to RUN with no period_valid pulse, because no prior edge exists.
REQ-026 RUN: each A rising edge SHALL latch period_out to the counter value (edges N cycles apart give N) and pulse period_valid.
REQ-027 RUN: when the counter reaches all-ones, the block SHALL go to STALL, set period_out to all-ones, pulse period_valid once, set stalled=1 and set direction=2'b00.
REQ-028 STALL: period_valid SHALL not pulse again while in STALL.
REQ-029 STALL: the next A rising edge SHALL go to ARM-equivalent RUN re-entry, clear stalled, and produce no period_valid, since the interval is unknown.
REQ-030 ARM: a counter reaching all-ones SHALL go to STALL with the same outputs as REQ-027.
REQ-031 Simultaneous A rising edge and counter saturation SHALL be treated as an edge.

Reset
REQ-032 Reset SHALL set the following: period_out=all-ones, period_valid=0, direction=2'b00, position=0, stalled=0, quad_error=0, state=ARM, counters=0.
REQ-033 Synchronizer and filter registers SHALL load 0 on reset.
REQ-034 Reset asserted mid-measurement SHALL discard any partial interval.
REQ-035 Reset SHALL take priority over every other input, including clear_pos.

Structure
REQ-036 A shared package SHALL hold the direction encodings (DIR_STOP, DIR_FWD, DIR_REV) and the state enum, which are reused by the ESC datapath.
REQ-037 One sub-module, enc_glitch_filter (synchronizer plus FILTER_LEN counter), SHALL be instantiated once per channel.

Verification
REQ-038 Forward quadrature with 25 cycles per step (A rising every 100) SHALL give, after the first edge, period_out=100 with period_valid on each edge, direction=2'b10 and position incrementing by 4 per A period.
REQ-039 A reverse sequence SHALL give direction=2'b01 and position decrementing to 0xFFFF at the first step from 0.
REQ-040 A 3-cycle glitch on A with FILTER_LEN=4 SHALL cause no position change and no quad_error.
REQ-041 With FILTER_LEN=4, A and B both toggling in the same cycle and held SHALL pulse quad_error once, 7 cycles after the pin change, with position unchanged.
REQ-042 No edges for 65535 cycles SHALL give stalled=1, period_out=0xFFFF and a single period_valid pulse; the next edge SHALL clear stalled with no period_valid.
REQ-043 clear_pos coincident with a forward step SHALL give position=0, and reset mid-run SHALL return all outputs to their reset values on the next cycle.

Source files
------------

// File: rtl/quad_encoder_speed_pkg.sv
// Shared encodings for quadrature decoding and speed measurement.
// Direction codes and the speed-measurement state type are also used by the ESC datapath.
package quad_encoder_speed_pkg;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_FWD  = 2'b10;
   localparam logic [1:0] DIR_REV  = 2'b01;

   localparam int unsigned FILT_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } speed_state_e;

   // Classify one {A,B} transition; a double-bit change and no change both return DIR_STOP.
   function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] res;
      res = DIR_STOP;
      case ({prev, cur})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: res = DIR_FWD;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: res = DIR_REV;
         default:                                res = DIR_STOP;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one encoder pin.
// A new level is accepted only after FILTER_LEN consecutive equal synchronized samples.
module enc_glitch_filter
   import quad_encoder_speed_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level
);

   logic                  sync1;
   logic                  sync2;
   logic [FILT_CNT_W-1:0] run_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         run_cnt <= '0;
         level   <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         if (sync2 == level) begin
            run_cnt <= '0;
         end else if (run_cnt == FILT_CNT_W'(FILTER_LEN - 1)) begin
            level   <= sync2;
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + FILT_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/quad_encoder_speed.sv
// Quadrature encoder decoder: filtered position/direction tracking plus
// A-edge period measurement with arm/run/stall supervision.
module quad_encoder_speed
   import quad_encoder_speed_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  encoder_a,
   input  logic                  encoder_b,
   input  logic                  clear_pos,
   output logic [DATA_WIDTH-1:0] period_out,
   output logic                  period_valid,
   output logic [1:0]            direction,
   output logic [DATA_WIDTH-1:0] position,
   output logic                  stalled,
   output logic                  quad_error
);

   localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

   logic                  a_filt;
   logic                  b_filt;
   logic [1:0]            ab_cur;
   logic [1:0]            ab_prev;
   logic [1:0]            step_c;
   logic                  a_rise_c;
   logic                  dbl_c;
   logic [DATA_WIDTH-1:0] period_cnt;
   speed_state_e          state;

   enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
      .clk   (clk),
      .reset (reset),
      .pin   (encoder_a),
      .level (a_filt)
   );

   enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
      .clk   (clk),
      .reset (reset),
      .pin   (encoder_b),
      .level (b_filt)
   );

   assign ab_cur   = {a_filt, b_filt};
   assign step_c   = quad_step(ab_prev, ab_cur);
   assign a_rise_c = a_filt & ~ab_prev[1];
   assign dbl_c    = (ab_prev ^ ab_cur) == 2'b11;

   always_ff @(posedge clk) begin
      if (reset) begin
         ab_prev      <= 2'b00;
         period_cnt   <= '0;
         period_out   <= CNT_MAX;
         period_valid <= 1'b0;
         direction    <= DIR_STOP;
         position     <= '0;
         stalled      <= 1'b0;
         quad_error   <= 1'b0;
         state        <= ST_ARM;
      end else begin
         ab_prev      <= ab_cur;
         quad_error   <= dbl_c;
         period_valid <= 1'b0;

         if (clear_pos)
            position <= '0;
         else if (step_c == DIR_FWD)
            position <= position + DATA_WIDTH'(1);
         else if (step_c == DIR_REV)
            position <= position - DATA_WIDTH'(1);

         if (step_c != DIR_STOP)
            direction <= step_c;

         if (a_rise_c)
            period_cnt <= DATA_WIDTH'(1);
         else if (period_cnt != CNT_MAX)
            period_cnt <= period_cnt + DATA_WIDTH'(1);

         // An A edge always wins over a coincident saturation; stall overrides any step direction.
         case (state)
            ST_ARM: begin
               if (a_rise_c) begin
                  state <= ST_RUN;
               end else if (period_cnt == CNT_MAX) begin
                  state        <= ST_STALL;
                  period_out   <= CNT_MAX;
                  period_valid <= 1'b1;
                  stalled      <= 1'b1;
                  direction    <= DIR_STOP;
               end
            end
            ST_RUN: begin
               if (a_rise_c) begin
                  period_out   <= period_cnt;
                  period_valid <= 1'b1;
               end else if (period_cnt == CNT_MAX) begin
                  state        <= ST_STALL;
                  period_out   <= CNT_MAX;
                  period_valid <= 1'b1;
                  stalled      <= 1'b1;
                  direction    <= DIR_STOP;
               end
            end
            ST_STALL: begin
               if (a_rise_c) begin
                  state   <= ST_RUN;
                  stalled <= 1'b0;
               end
            end
            default: state <= ST_ARM;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_encoder_speed.sv
// Directed bench for quad_encoder_speed: position/direction checks plus a
// period_valid scoreboard fed by the stimulus and drained from observed pulses.
module tb_quad_encoder_speed;

   localparam int unsigned DW = 16;
   localparam int unsigned FL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          encoder_a;
   logic          encoder_b;
   logic          clear_pos;
   logic [DW-1:0] period_out;
   logic          period_valid;
   logic [1:0]    direction;
   logic [DW-1:0] position;
   logic          stalled;
   logic          quad_error;

   int            n_cmp = 0;
   int            n_err = 0;
   int            qerr_cnt = 0;
   int            qidx = 0;
   logic [DW-1:0] model_pos = '0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] obs_q[$];

   quad_encoder_speed #(.DATA_WIDTH(DW), .FILTER_LEN(FL)) dut (
      .clk          (clk),
      .reset        (reset),
      .encoder_a    (encoder_a),
      .encoder_b    (encoder_b),
      .clear_pos    (clear_pos),
      .period_out   (period_out),
      .period_valid (period_valid),
      .direction    (direction),
      .position     (position),
      .stalled      (stalled),
      .quad_error   (quad_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [1:0] gray(input int i);
      case (i % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic drive_idx();
      {encoder_a, encoder_b} = gray(qidx);
   endtask

   // One quadrature step followed by 25 idle cycles.
   task automatic step(input bit fwd);
      qidx = fwd ? (qidx + 1) % 4 : (qidx + 3) % 4;
      drive_idx();
      model_pos = fwd ? model_pos + DW'(1) : model_pos - DW'(1);
      repeat (25) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_pos = 1'b0;
      qidx = 0;
      drive_idx();
      model_pos = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic drain(input string tag);
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0)
         chk(tag, obs_q.pop_front(), exp_q.pop_front());
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_period_out"}, period_out, 32'hFFFF);
      chk({tag, "_period_valid"}, period_valid, 0);
      chk({tag, "_direction"}, direction, 0);
      chk({tag, "_position"}, position, 0);
      chk({tag, "_stalled"}, stalled, 0);
      chk({tag, "_quad_error"}, quad_error, 0);
   endtask

   initial begin
      int q0;
      int qe_hits;
      int qe_at;
      reset = 1'b1;
      clear_pos = 1'b0;
      encoder_a = 1'b0;
      encoder_b = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (!reset) begin
               if (period_valid) obs_q.push_back(period_out);
               if (quad_error) qerr_cnt++;
            end
         end
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      reset = 1'b0;
      @(negedge clk);

      // Forward: 25 cycles/step, A rises at steps 2, 6, 10
      do_reset();
      for (int i = 1; i <= 12; i++) begin
         if (i == 6 || i == 10) exp_q.push_back(DW'(100));
         step(1'b1);
         chk("fwd_pos", position, model_pos);
      end
      chk("fwd_dir", direction, 2'b10);
      chk("fwd_period", period_out, 100);
      drain("fwd_pv");

      // Reverse: first step wraps to 0xFFFF, A rises at steps 1 and 5
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         if (i == 5) exp_q.push_back(DW'(100));
         step(1'b0);
         if (i == 1) chk("rev_first_pos", position, 32'hFFFF);
      end
      chk("rev_pos", position, 32'hFFF8);
      chk("rev_dir", direction, 2'b01);
      drain("rev_pv");

      // Glitch of 3 cycles on A is rejected
      do_reset();
      q0 = qerr_cnt;
      encoder_a = 1'b1;
      repeat (3) @(negedge clk);
      encoder_a = 1'b0;
      repeat (20) @(negedge clk);
      chk("glitch_pos", position, 0);
      chk("glitch_qerr", qerr_cnt - q0, 0);
      chk("glitch_dir", direction, 0);

      // Double-bit change: one quad_error pulse exactly 7 cycles later
      do_reset();
      qe_hits = 0;
      qe_at = 0;
      qidx = 2;
      drive_idx();
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (quad_error) begin
            qe_hits++;
            if (qe_at == 0) qe_at = i;
         end
      end
      chk("qerr_pulses", qe_hits, 1);
      chk("qerr_latency", qe_at, FL + 3);
      chk("qerr_pos", position, 0);
      chk("qerr_dir", direction, 0);

      // clear_pos coincident with a forward step wins
      do_reset();
      repeat (3) step(1'b1);
      chk("clr_pre_pos", position, 3);
      qidx = 0;
      drive_idx();
      repeat (FL + 2) @(negedge clk);
      clear_pos = 1'b1;
      @(negedge clk);
      clear_pos = 1'b0;
      repeat (20) @(negedge clk);
      chk("clr_pos", position, 0);
      model_pos = '0;
      for (int i = 1; i <= 8; i++) step(1'b1);
      chk("run_pos", position, 8);
      chk("run_period", period_out, 100);
      chk("run_dir", direction, 2'b10);

      // Reset mid-run returns outputs to reset values and discards the interval
      @(negedge clk);
      reset = 1'b1;
      qidx = 0;
      drive_idx();
      model_pos = '0;
      @(negedge clk);
      chk_reset_outputs("midrst");
      reset = 1'b0;
      obs_q.delete();
      exp_q.delete();
      step(1'b1);
      step(1'b1);
      chk("midrst_pos", position, 2);
      drain("midrst_pv");

      // Stall after 65535 idle cycles: single valid with all-ones, direction stopped
      do_reset();
      step(1'b1);
      chk("stall_pre_dir", direction, 2'b10);
      exp_q.push_back('1);
      for (int i = 0; i < 70000 && !stalled; i++) @(negedge clk);
      chk("stall_flag", stalled, 1);
      chk("stall_period", period_out, 32'hFFFF);
      chk("stall_dir", direction, 0);
      repeat (300) @(negedge clk);
      drain("stall_pv");
      qidx = 2;
      drive_idx();
      repeat (15) @(negedge clk);
      chk("unstall_flag", stalled, 0);
      drain("unstall_pv");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
